// File: rtl/bp_fe_replay_fifo.sv
`default_nettype none
// ============================================================================
// bp_fe_replay_fifo : in-order fetch replay queue with multi-entry commit,
// in-flight issue cap and rollback. Optional BP_FE_REPLAY_FIFO_STATS_EN.
// Revision: 1.0
// ============================================================================
module bp_fe_replay_fifo #(
  parameter int width_p        = 64,
  parameter int els_p          = 8,
  parameter int max_inflight_p = 8,
  parameter int commit_width_p = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [width_p-1:0]                  data_i,
  input  logic                                v_i,
  output logic                                ready_o,
  output logic [width_p-1:0]                  data_o,
  output logic                                v_o,
  input  logic                                yumi_i,
  input  logic [$clog2(commit_width_p+1)-1:0] deq_cnt_i,
  input  logic                                roll_v_i,
  input  logic                                clr_v_i,
  output logic [$clog2(els_p+1)-1:0]          occupancy_o,
  output logic [$clog2(els_p+1)-1:0]          inflight_o,
  output logic [31:0]                         stat_roll_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p) + 1;
  localparam int idx_w_lp = ptr_w_lp - 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]  mem_q [els_p];

  logic [ptr_w_lp-1:0] occ;
  logic [ptr_w_lp-1:0] infl;
  logic                enq;

  // Differences are taken modulo 2*els_p; the wrap bit separates full from empty.
  assign occ  = wptr_q - cptr_q;
  assign infl = rptr_q - cptr_q;

  assign ready_o = ~reset_i & ~clr_v_i & (occ < ptr_w_lp'(els_p));
  assign enq     = v_i & ready_o;

  assign v_o    = ~reset_i & (wptr_q != rptr_q) & (infl < ptr_w_lp'(max_inflight_p));
  assign data_o = mem_q[rptr_q[idx_w_lp-1:0]];

  assign occupancy_o = reset_i ? '0 : cnt_w_lp'(occ);
  assign inflight_o  = reset_i ? '0 : cnt_w_lp'(infl);

  // Commit always lands; roll and clear rewind onto the post-commit pointer.
  always_comb begin
    cptr_d = cptr_q + ptr_w_lp'(deq_cnt_i);
    rptr_d = rptr_q + ptr_w_lp'(yumi_i);
    wptr_d = wptr_q + ptr_w_lp'(enq);
    if (roll_v_i | clr_v_i) begin
      rptr_d = cptr_d;
    end
    if (clr_v_i) begin
      wptr_d = cptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_w_lp-1:0]] <= data_i;
    end
  end

`ifdef BP_FE_REPLAY_FIFO_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if ((roll_v_i | clr_v_i) && (infl != '0) && (stat_q != 32'hFFFF_FFFF)) begin
      stat_d = stat_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_roll_cnt_o = stat_q;
`else
  assign stat_roll_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (ptr_w_lp'(deq_cnt_i) <= infl)
        else $error("bp_fe_replay_fifo: deq_cnt_i exceeds in-flight count");
      assert (32'(deq_cnt_i) <= 32'(commit_width_p))
        else $error("bp_fe_replay_fifo: deq_cnt_i exceeds commit width");
      assert (!(yumi_i && !v_o))
        else $error("bp_fe_replay_fifo: yumi_i without v_o");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_replay_fifo.sv
`default_nettype none
// ============================================================================
// tb_bp_fe_replay_fifo : directed bench for bp_fe_replay_fifo (els_p=8) plus
// a second instance with max_inflight_p=2. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bp_fe_replay_fifo;

  localparam int W = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         reset_i;
  logic [W-1:0] data_i, data_o;
  logic         v_i, ready_o, v_o, yumi_i, roll_v_i, clr_v_i;
  logic [1:0]   deq_cnt_i;
  logic [3:0]   occupancy_o, inflight_o;
  logic [31:0]  stat_o;

  logic [W-1:0] c_data_i, c_data_o;
  logic         c_v_i, c_ready_o, c_v_o, c_yumi_i, c_roll_v_i, c_clr_v_i;
  logic [1:0]   c_deq_cnt_i;
  logic [3:0]   c_occupancy_o, c_inflight_o;
  logic [31:0]  c_stat_o;

  int checks   = 0;
  int failures = 0;
  int exp_stat;

  bp_fe_replay_fifo #(.width_p(W), .els_p(8), .max_inflight_p(8), .commit_width_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .deq_cnt_i(deq_cnt_i),
    .roll_v_i(roll_v_i), .clr_v_i(clr_v_i), .occupancy_o(occupancy_o),
    .inflight_o(inflight_o), .stat_roll_cnt_o(stat_o)
  );

  bp_fe_replay_fifo #(.width_p(W), .els_p(8), .max_inflight_p(2), .commit_width_p(2)) dut_cap (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(c_data_i), .v_i(c_v_i), .ready_o(c_ready_o),
    .data_o(c_data_o), .v_o(c_v_o), .yumi_i(c_yumi_i), .deq_cnt_i(c_deq_cnt_i),
    .roll_v_i(c_roll_v_i), .clr_v_i(c_clr_v_i), .occupancy_o(c_occupancy_o),
    .inflight_o(c_inflight_o), .stat_roll_cnt_o(c_stat_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    v_i = 0; data_i = '0; yumi_i = 0; deq_cnt_i = '0; roll_v_i = 0; clr_v_i = 0;
    c_v_i = 0; c_data_i = '0; c_yumi_i = 0; c_deq_cnt_i = '0; c_roll_v_i = 0; c_clr_v_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
    #1;
  endtask

  initial begin
    reset_i = 1;
    idle();
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_v", v_o, 0);
    check("rst_occ", occupancy_o, 0);
    check("rst_infl", inflight_o, 0);
    check("rst_stat", stat_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 0;
    #1;

    // Fill / drain
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", ready_o, 1);
      v_i = 1; data_i = W'(i);
      tick();
    end
    check("full_ready", ready_o, 0);
    check("full_occ", occupancy_o, 8);
    for (int i = 0; i < 8; i++) begin
      check("drain_v", v_o, 1);
      check("drain_data", data_o, i);
      yumi_i = 1;
      tick();
    end
    check("drained_v", v_o, 0);
    check("drained_infl", inflight_o, 8);
    for (int k = 0; k < 4; k++) begin
      deq_cnt_i = 2;
      #1;
      if (k == 0) check("commit_no_bypass", ready_o, 0);
      tick();
      check("commit_occ", occupancy_o, 6 - 2 * k);
    end
    check("empty_ready", ready_o, 1);

    // Roll
    v_i = 1; data_i = 16'h000A; tick();
    v_i = 1; data_i = 16'h000B; tick();
    v_i = 1; data_i = 16'h000C; tick();
    check("roll_a", data_o, 16'h000A); yumi_i = 1; tick();
    check("roll_b", data_o, 16'h000B); yumi_i = 1; tick();
    deq_cnt_i = 1; tick();
    check("roll_pre_infl", inflight_o, 1);
    roll_v_i = 1; tick();
    check("roll_data", data_o, 16'h000B);
    check("roll_infl", inflight_o, 0);
    check("roll_occ", occupancy_o, 2);
    yumi_i = 1; tick();
    check("roll_c", data_o, 16'h000C); yumi_i = 1; deq_cnt_i = 1; tick();
    deq_cnt_i = 1; tick();
    check("roll_done_occ", occupancy_o, 0);

    // Roll + yumi + commit in one cycle
    v_i = 1; data_i = 16'h0021; tick();
    v_i = 1; data_i = 16'h0022; tick();
    v_i = 1; data_i = 16'h0023; tick();
    yumi_i = 1; tick();
    yumi_i = 1; tick();
    check("combo_z", data_o, 16'h0023);
    yumi_i = 1; deq_cnt_i = 1; roll_v_i = 1; tick();
    check("combo_data_y", data_o, 16'h0022);
    check("combo_infl", inflight_o, 0);
    check("combo_occ", occupancy_o, 2);
    yumi_i = 1; tick();
    check("combo_replay_z", data_o, 16'h0023);
    yumi_i = 1; tick();
    deq_cnt_i = 2; tick();
    check("combo_done_occ", occupancy_o, 0);

    // Clear
    for (int i = 0; i < 5; i++) begin
      v_i = 1; data_i = W'(16'h0031 + i); tick();
    end
    for (int i = 0; i < 3; i++) begin
      yumi_i = 1; tick();
    end
    check("clr_pre_infl", inflight_o, 3);
    v_i = 1; data_i = 16'h0099; deq_cnt_i = 1; clr_v_i = 1;
    #1;
    check("clr_ready", ready_o, 0);
    tick();
    check("clr_occ", occupancy_o, 0);
    check("clr_v", v_o, 0);
    check("clr_infl", inflight_o, 0);
    v_i = 1; data_i = 16'h0040; tick();
    check("clr_fresh_data", data_o, 16'h0040);
    check("clr_fresh_occ", occupancy_o, 1);
    yumi_i = 1; tick();
    deq_cnt_i = 1; tick();

    // Wrap: 20 entries through an enq/issue/commit pipeline
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin v_i = 1; data_i = W'(16'h0100 + i); end
      if (i >= 1 && i <= 20) yumi_i = 1;
      if (i >= 2) deq_cnt_i = 1;
      #1;
      check("wrap_v", v_o, (i >= 1 && i <= 20) ? 1 : 0);
      if (i >= 1 && i <= 20) check("wrap_data", data_o, 16'h0100 + i - 1);
      if (i >= 2 && i <= 20) check("wrap_occ", occupancy_o, 2);
      tick();
    end
    check("wrap_end_occ", occupancy_o, 0);

`ifdef BP_FE_REPLAY_FIFO_STATS_EN
    exp_stat = 3;
`else
    exp_stat = 0;
`endif
    check("stat_before_reset", stat_o, exp_stat);

    // Async reset mid-burst
    v_i = 1; data_i = 16'h0051; tick();
    v_i = 1; data_i = 16'h0052; tick();
    v_i = 1; data_i = 16'h0053; tick();
    v_i = 1; data_i = 16'h0054; yumi_i = 1;
    reset_i = 1;
    #1;
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_v", v_o, 0);
    check("mid_rst_occ", occupancy_o, 0);
    check("mid_rst_infl", inflight_o, 0);
    check("mid_rst_stat", stat_o, 0);
    tick();
    reset_i = 0;
    #1;
    check("post_rst_occ", occupancy_o, 0);
    check("post_rst_v", v_o, 0);
    check("post_rst_ready", ready_o, 1);

    // In-flight cap on the max_inflight_p=2 instance
    for (int i = 0; i < 4; i++) begin
      c_v_i = 1; c_data_i = W'(16'h0060 + i); tick();
    end
    check("cap_occ", c_occupancy_o, 4);
    check("cap_v0", c_v_o, 1); check("cap_d0", c_data_o, 16'h0060);
    c_yumi_i = 1; tick();
    check("cap_v1", c_v_o, 1); check("cap_d1", c_data_o, 16'h0061);
    c_yumi_i = 1; tick();
    check("cap_blocked_v", c_v_o, 0);
    check("cap_blocked_infl", c_inflight_o, 2);
    c_deq_cnt_i = 1; tick();
    check("cap_release_v", c_v_o, 1);
    check("cap_release_data", c_data_o, 16'h0062);
    check("cap_release_infl", c_inflight_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
